pipelined_adder: RTL and testbench

//  WIDTH-bit adder, a + b + cin, split into STAGES equal slices.

---
 rtl/pipelined_adder_pkg.sv | 28 ++
 rtl/pipelined_adder_if.sv | 37 +++
 rtl/pipelined_adder_slice.sv | 22 ++
 rtl/pipelined_adder.sv | 105 ++++++++++
 tb/tb_pipelined_adder.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared types and helpers for pipelined_adder.
//   slice_w()  : per-stage slice width (WIDTH / STAGES)
//   stage_t    : per-stage pipeline record; fields sized to MAX_W so one
//                typedef serves every WIDTH up to MAX_W
//   STAGE_RST  : value of a stage register after reset
package pipelined_adder_pkg;

  localparam int MAX_W = 64;

  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

  // a_rem/b_rem are shifted right by one slice per stage, so the slice a
  // stage consumes always sits in the low bits. sum_done collects finished
  // slices at their final bit positions.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [MAX_W-1:0] a_rem;
    logic [MAX_W-1:0] b_rem;
    logic [MAX_W-1:0] sum_done;
  } stage_t;

  localparam stage_t STAGE_RST = '{valid: 1'b0, carry: 1'b0,
                                   a_rem: '0, b_rem: '0, sum_done: '0};

endpackage

// File: rtl/pipelined_adder_if.sv
// Handshake bundle for pipelined_adder.
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : the adder (drives in_ready and results)
// Optional: PIPELINED_ADDER_SUB_EN adds the 1-bit `sub` operand.
interface pipelined_adder_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef PIPELINED_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin,
`ifdef PIPELINED_ADDER_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin,
`ifdef PIPELINED_ADDER_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder_slice.sv
// adder_slice: SW-bit combinational ripple add.
//   a, b, ci  : slice operands and carry in
//   s, co     : slice sum and carry out
//   c_msb_in  : carry into the slice MSB (for signed overflow at the top)
module adder_slice #(
  parameter int SW = 4
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          ci,
  output logic [SW-1:0] s,
  output logic          co,
  output logic          c_msb_in
);
  logic [SW:0] t;

  assign t        = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, ci};
  assign s        = t[SW-1:0];
  assign co       = t[SW];
  // sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out directly
  assign c_msb_in = a[SW-1] ^ b[SW-1] ^ s[SW-1];
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit a + b + cin split into STAGES slices with
// registered inter-slice carries; one beat/cycle, STAGES-cycle latency.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : pipelined_adder_if.slave (in_valid/in_ready/a/b/cin,
//                out_valid/out_ready/sum/cout/ovf)
// Optional: PIPELINED_ADDER_SUB_EN -> bus.sub selects a - b (b inverted,
// stage-0 carry forced to 1, cin ignored; cout = 1 means no borrow).
// The whole pipe advances together whenever the output slot is free or
// being consumed; bubbles are not collapsed.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic              clk,
  input logic              rst_n,
  pipelined_adder_if.slave bus
);
  localparam int SW = slice_w(WIDTH, STAGES);

  if (WIDTH % STAGES != 0) begin : g_chk_div
    $error("pipelined_adder: WIDTH %0d not a multiple of STAGES %0d", WIDTH, STAGES);
  end
  if (STAGES < 1 || STAGES > WIDTH || WIDTH > MAX_W) begin : g_chk_rng
    $error("pipelined_adder: bad WIDTH %0d / STAGES %0d", WIDTH, STAGES);
  end

  logic             adv, acc, c0, ovf_q;
  logic [WIDTH-1:0] b_eff;
  stage_t           last;

  assign adv          = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = adv;
  assign acc          = bus.in_valid & adv;

`ifdef PIPELINED_ADDER_SUB_EN
  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign c0    = bus.sub | bus.cin;
`else
  assign b_eff = bus.b;
  assign c0    = bus.cin;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    stage_t        d, q;
    logic [SW-1:0] s;
    logic          co, cm;

    if (k == 0) begin : g_src0
      // A non-accepting cycle still loads stage 0, just with valid = 0.
      always_comb begin
        d       = STAGE_RST;
        d.valid = acc;
        d.carry = c0;
        d.a_rem = MAX_W'(bus.a);
        d.b_rem = MAX_W'(b_eff);
      end
    end else begin : g_srcn
      assign d = g_stg[k-1].q;
    end

    adder_slice #(.SW(SW)) u_slice (
      .a        (d.a_rem[SW-1:0]),
      .b        (d.b_rem[SW-1:0]),
      .ci       (d.carry),
      .s        (s),
      .co       (co),
      .c_msb_in (cm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= STAGE_RST;
      end else if (adv) begin
        q                     <= d;
        q.carry               <= co;
        q.a_rem               <= d.a_rem >> SW;
        q.b_rem               <= d.b_rem >> SW;
        q.sum_done[k*SW +: SW] <= s;
      end
    end

    if (k == STAGES-1) begin : g_last
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   ovf_q <= 1'b0;
        else if (adv) ovf_q <= cm ^ co;
      end
    end else begin : g_mid
      logic unused_cm;
      assign unused_cm = cm;
    end
  end

  assign last          = g_stg[STAGES-1].q;
  assign bus.out_valid = last.valid;
  assign bus.sum       = last.sum_done[WIDTH-1:0];
  assign bus.cout      = last.carry;
  assign bus.ovf       = ovf_q;

  // Operand remnants and sum bits above WIDTH are dead at the output.
  logic unused_tail;
  assign unused_tail = ^{last.a_rem, last.b_rem, last.sum_done};
endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: table vectors, back-to-back
// stream, backpressure, mid-stream reset, random sweep, plus WIDTH=8/
// STAGES=1 and WIDTH=32/STAGES=8 instances checked against the same model.
module tb_pipelined_adder;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(16)) bus ();
  pipelined_adder_if #(.WIDTH(8))  b8  ();
  pipelined_adder_if #(.WIDTH(32)) b32 ();

  pipelined_adder #(.WIDTH(16), .STAGES(S)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  pipelined_adder #(.WIDTH(8),  .STAGES(1)) dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  pipelined_adder #(.WIDTH(32), .STAGES(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
    bit          lat;
  } exp_t;

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] sum;
    logic        cout, ovf;
  } vec_t;

  exp_t        q16[$];
  logic [65:0] q8[$], q32[$];
  vec_t        tab[$];
  int          checks = 0, errors = 0, cyc = 0, n_out = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Returns {ovf, cout, sum[63:0]} for a w-bit add/subtract.
  function automatic logic [65:0] model(input logic [63:0] a, b, input logic cin, sub, input int w);
    logic [63:0] m, aa, bb, s;
    logic [64:0] full;
    logic        c0, co, ov;
    m    = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    aa   = a & m;
    bb   = (sub ? ~b : b) & m;
    c0   = sub ? 1'b1 : cin;
    full = {1'b0, aa} + {1'b0, bb} + {64'd0, c0};
    s    = full[63:0] & m;
    co   = full[w];
    ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    return {ov, co, s};
  endfunction

  // Main output monitor plus drive/check of the two extra instances.
  always @(negedge clk) begin
    exp_t        e;
    logic [65:0] r;
    logic        s8, s32;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q16.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out: got beat sum=%h, expected no beat", bus.sum);
      end else begin
        e = q16.pop_front();
        n_out++;
        chk("sum", 64'(bus.sum), 64'(e.sum));
        chk("cout", 64'(bus.cout), 64'(e.cout));
        chk("ovf", 64'(bus.ovf), 64'(e.ovf));
        if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'(S));
      end
    end
`ifdef PIPELINED_ADDER_SUB_EN
    s8 = b8.sub; s32 = b32.sub;
`else
    s8 = 1'b0; s32 = 1'b0;
`endif
    if (rst_n && b8.in_valid && b8.in_ready)
      q8.push_back(model(64'(b8.a), 64'(b8.b), b8.cin, s8, 8));
    if (rst_n && b32.in_valid && b32.in_ready)
      q32.push_back(model(64'(b32.a), 64'(b32.b), b32.cin, s32, 32));
    if (rst_n && b8.out_valid) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL w8_unexpected: got beat sum=%h, expected no beat", b8.sum);
      end else begin
        r = q8.pop_front();
        chk("w8_sum", 64'(b8.sum), r[63:0]);
        chk("w8_flags", {62'd0, b8.cout, b8.ovf}, {62'd0, r[64], r[65]});
      end
    end
    if (rst_n && b32.out_valid) begin
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL w32_unexpected: got beat sum=%h, expected no beat", b32.sum);
      end else begin
        r = q32.pop_front();
        chk("w32_sum", 64'(b32.sum), r[63:0]);
        chk("w32_flags", {62'd0, b32.cout, b32.ovf}, {62'd0, r[64], r[65]});
      end
    end
  end

  // Drive one beat from posedge+1; push its expected result when accepted.
  task automatic send(input logic [15:0] a, b, input logic cin, sub, input bit lat,
                      input logic [15:0] e_sum, input logic e_cout, e_ovf, output int waited);
    exp_t e;
    bus.a = a; bus.b = b; bus.cin = cin;
`ifdef PIPELINED_ADDER_SUB_EN
    bus.sub = sub;
`endif
    bus.in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready got 0, expected 1");
    end else begin
      e = '{sum: e_sum, cout: e_cout, ovf: e_ovf, cyc: cyc, lat: lat};
      q16.push_back(e);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [15:0] a, b, input logic cin, sub, input bit lat, output int waited);
    logic [65:0] r;
    r = model(64'(a), 64'(b), cin, sub, 16);
    send(a, b, cin, sub, lat, r[15:0], r[64], r[65], waited);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (q16.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(q16.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation got stuck, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w, base;
    logic [15:0] held;
    logic        sv;
    bit          sweep_done;

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b1;
    b8.in_valid  = 1'b0; b8.a  = '0; b8.b  = '0; b8.cin  = 1'b0; b8.out_ready  = 1'b1;
    b32.in_valid = 1'b0; b32.a = '0; b32.b = '0; b32.cin = 1'b0; b32.out_ready = 1'b1;
`ifdef PIPELINED_ADDER_SUB_EN
    bus.sub = 1'b0; b8.sub = 1'b0; b32.sub = 1'b0;
`endif

    tab.push_back('{a: 16'h1234, b: 16'h0FED, cin: 1, sub: 0, sum: 16'h2222, cout: 0, ovf: 0});
    tab.push_back('{a: 16'hFFFF, b: 16'h0000, cin: 1, sub: 0, sum: 16'h0000, cout: 1, ovf: 0});
    tab.push_back('{a: 16'h7FFF, b: 16'h0001, cin: 0, sub: 0, sum: 16'h8000, cout: 0, ovf: 1});
    tab.push_back('{a: 16'h8000, b: 16'h8000, cin: 0, sub: 0, sum: 16'h0000, cout: 1, ovf: 1});
    tab.push_back('{a: 16'hFFFF, b: 16'hFFFF, cin: 1, sub: 0, sum: 16'hFFFF, cout: 1, ovf: 0});
    tab.push_back('{a: 16'h00FF, b: 16'h0001, cin: 0, sub: 0, sum: 16'h0100, cout: 0, ovf: 0});
    tab.push_back('{a: 16'h0FFF, b: 16'h0001, cin: 0, sub: 0, sum: 16'h1000, cout: 0, ovf: 0});
    tab.push_back('{a: 16'hAAAA, b: 16'h5555, cin: 1, sub: 0, sum: 16'h0000, cout: 1, ovf: 0});
    tab.push_back('{a: 16'h0000, b: 16'h0000, cin: 0, sub: 0, sum: 16'h0000, cout: 0, ovf: 0});
`ifdef PIPELINED_ADDER_SUB_EN
    tab.push_back('{a: 16'h0005, b: 16'h0007, cin: 0, sub: 1, sum: 16'hFFFE, cout: 0, ovf: 0});
    tab.push_back('{a: 16'h8000, b: 16'h0001, cin: 0, sub: 1, sum: 16'h7FFF, cout: 1, ovf: 1});
    tab.push_back('{a: 16'h1234, b: 16'h1234, cin: 0, sub: 1, sum: 16'h0000, cout: 1, ovf: 0});
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #3;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_sum", 64'(bus.sum), 64'd0);
    chk("rst_cout", 64'(bus.cout), 64'd0);
    chk("rst_ovf", 64'(bus.ovf), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors, back-to-back, latency checked
    foreach (tab[i])
      send(tab[i].a, tab[i].b, tab[i].cin, tab[i].sub, 1'b1,
           tab[i].sum, tab[i].cout, tab[i].ovf, w);
    drain("tab_drain");

    // Back-to-back stream: 8 beats, in_ready must never drop
    for (int i = 0; i < 8; i++) begin
      send_m(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 1'b1, w);
      chk("stream_in_ready_wait", 64'(w), 64'd0);
    end
    drain("stream_drain");

    // Backpressure: stall the output for 5 cycles mid-stream
    base = n_out;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send_m(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 1'b0, w);
      end
      begin
        int n = 0;
        @(posedge clk); #1;
        while (!bus.out_valid && n < 50) begin
          @(posedge clk); #1;
          n++;
        end
        chk("bp_reach_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b0;
        held = bus.sum;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
          chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
          chk("bp_sum_stable", 64'(bus.sum), 64'(held));
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    chk("bp_count", 64'(n_out - base), 64'd10);

    // Reset with 3 beats in flight
    for (int i = 0; i < 3; i++)
      send_m(16'h1111 * 16'(i + 1), 16'h0F0F, 1'b1, 1'b0, 1'b0, w);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_sum", 64'(bus.sum), 64'd0);
    q16.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    base = n_out;
    send_m(16'h4321, 16'h1234, 1'b0, 1'b0, 1'b1, w);
    drain("postrst_drain");
    repeat (6) @(posedge clk);
    #1;
    chk("postrst_count", 64'(n_out - base), 64'd1);

    // Random sweep with random output backpressure
    sweep_done = 1'b0;
    base = n_out;
    fork
      begin
`ifdef PIPELINED_ADDER_SUB_EN
        for (int i = 0; i < 1000; i++) begin
          sv = 1'($urandom);
`else
        for (int i = 0; i < 300; i++) begin
          sv = 1'b0;
`endif
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          send_m(16'($urandom), 16'($urandom), 1'($urandom), sv, 1'b0, w);
        end
        sweep_done = 1'b1;
      end
      begin
        while (!sweep_done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain("sweep_drain");

    // Other widths/depths: free-running random stream, out_ready held 1
    for (int i = 0; i < 200; i++) begin
      b8.in_valid  = 1'($urandom); b8.a  = 8'($urandom); b8.b  = 8'($urandom); b8.cin  = 1'($urandom);
      b32.in_valid = 1'($urandom); b32.a = $urandom;     b32.b = $urandom;     b32.cin = 1'($urandom);
`ifdef PIPELINED_ADDER_SUB_EN
      b8.sub = 1'($urandom); b32.sub = 1'($urandom);
`endif
      @(posedge clk); #1;
    end
    b8.in_valid = 1'b0; b32.in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("w8_drain", 64'(q8.size()), 64'd0);
    chk("w32_drain", 64'(q32.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
